mem_responder: RTL and testbench

- Memory-side responder for the hart's memory port (addr, wwidth, wenable, wdata, rdata).
- Contains a word-organised RAM with byte-lane write masking and a 2-cycle registered read pipeline. This matches the hart's READ_CYCLE_LATENCY = 2.
- Also contains one memory-mapped output register and a sticky access-fault monitor, so illegal accesses become visible instead of silently corrupting state.

---
 rtl/mem_responder.sv | 143 ++++++++++++++
 tb/tb_mem_responder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder: byte-lane RAM with a 2-stage read pipeline, one
// memory-mapped output register and a sticky first-fault monitor.
package mem_responder_pkg;
  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    write_byte     = 2'd0,
    write_halfword = 2'd1,
    write_word     = 2'd2
  } write_width_t;
endpackage

module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned     DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] IO_ADDR     = 32'h0000_F000,
  parameter                  INIT_FILE   = ""
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] mem_addr,
  input  write_width_t    mem_wwidth,
  input  logic            mem_wenable,
  input  logic [XLEN-1:0] mem_wdata,
  output logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] io_out,
  output logic            io_strobe,
  output logic            access_fault,
  output logic [XLEN-1:0] fault_addr
);

  localparam int unsigned     IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [XLEN-1:0] RAM_BYTES = XLEN'(DEPTH_WORDS * 4);

  logic [XLEN-1:0] ram [DEPTH_WORDS];

  logic [IDX_W-1:0] idx;
  logic             ram_hit;
  logic             io_hit;
  logic             unmapped;
  logic [3:0]       lane_mask;
  logic [XLEN-1:0]  lane_data;
  logic             misaligned;
  logic             wr_ok;
  logic             ram_we;
  logic             io_we;
  logic             addr_held;
  logic             fault_now;
  logic [XLEN-1:0]  read_word;

  logic [XLEN-1:0]  s1_word;
  logic [1:0]       s1_off;
  logic [XLEN-1:0]  prev_addr;
  logic             prev_valid;

  function automatic logic [XLEN-1:0] merge_lanes(input logic [XLEN-1:0] old,
                                                  input logic [XLEN-1:0] data,
                                                  input logic [3:0]      mask);
    merge_lanes = old;
    for (int unsigned i = 0; i < 4; i++) begin
      if (mask[i]) merge_lanes[8*i +: 8] = data[8*i +: 8];
    end
  endfunction

  assign idx = mem_addr[IDX_W+1:2];

  // RAM takes priority should IO_ADDR ever be placed inside the RAM window.
  always_comb begin
    ram_hit  = (mem_addr < RAM_BYTES);
    io_hit   = !ram_hit && (mem_addr[XLEN-1:2] == IO_ADDR[XLEN-1:2]);
    unmapped = !ram_hit && !io_hit;
  end

  always_comb begin
    lane_mask  = '0;
    lane_data  = mem_wdata;
    misaligned = 1'b0;
    case (mem_wwidth)
      write_byte: begin
        lane_mask = 4'b0001 << mem_addr[1:0];
        lane_data = {4{mem_wdata[7:0]}};
      end
      write_halfword: begin
        misaligned = mem_addr[0];
        lane_mask  = mem_addr[1] ? 4'b1100 : 4'b0011;
        lane_data  = {2{mem_wdata[15:0]}};
      end
      write_word: begin
        misaligned = |mem_addr[1:0];
        lane_mask  = '1;
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_ok     = mem_wenable && !reset && !misaligned && !unmapped;
    ram_we    = wr_ok && ram_hit;
    io_we     = wr_ok && io_hit;
    // An unmapped read only counts once the address has been held across an edge.
    addr_held = prev_valid && (mem_addr == prev_addr);
    fault_now = (mem_wenable && (misaligned || unmapped)) ||
                (!mem_wenable && unmapped && addr_held);
  end

  always_comb begin
    read_word = '0;
    if (ram_hit)     read_word = ram[idx];
    else if (io_hit) read_word = io_out;
  end

  always_ff @(posedge clock) begin
    if (ram_we) ram[idx] <= merge_lanes(ram[idx], lane_data, lane_mask);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_word      <= '0;
      s1_off       <= '0;
      mem_rdata    <= '0;
      io_out       <= '0;
      io_strobe    <= 1'b0;
      access_fault <= 1'b0;
      fault_addr   <= '0;
      prev_addr    <= '0;
      prev_valid   <= 1'b0;
    end else begin
      s1_word   <= read_word;
      s1_off    <= mem_addr[1:0];
      mem_rdata <= s1_word >> {s1_off, 3'b000};
      if (io_we) io_out <= merge_lanes(io_out, lane_data, lane_mask);
      io_strobe <= io_we;
      if (fault_now) begin
        access_fault <= 1'b1;
        if (!access_fault) fault_addr <= mem_addr;
      end
      prev_addr  <= mem_addr;
      prev_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: byte-addressed reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_responder;
   import mem_responder_pkg::*;

   localparam logic [31:0] IO = 32'h0000_F000;

   logic         clock;
   logic         reset;
   logic [31:0]  mem_addr;
   write_width_t mem_wwidth;
   logic         mem_wenable;
   logic [31:0]  mem_wdata;
   logic [31:0]  mem_rdata;
   logic [31:0]  io_out;
   logic         io_strobe;
   logic         access_fault;
   logic [31:0]  fault_addr;

   int nchecks = 0;
   int nerrors = 0;

   mem_responder #(
      .DEPTH_WORDS(1024),
      .IO_ADDR(32'h0000_F000),
      .INIT_FILE("")
   ) dut (
      .clock(clock),
      .reset(reset),
      .mem_addr(mem_addr),
      .mem_wwidth(mem_wwidth),
      .mem_wenable(mem_wenable),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .io_out(io_out),
      .io_strobe(io_strobe),
      .access_fault(access_fault),
      .fault_addr(fault_addr)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference state: memory as individually tracked bytes.
   logic [7:0]  mb  [0:4095];
   logic        kb  [0:4095];
   logic [7:0]  iob [0:3];
   logic [31:0] stage_val;
   logic        stage_known;
   logic [31:0] exp_rdata;
   logic        exp_rknown;
   logic        exp_strobe;
   logic        exp_fault;
   logic [31:0] exp_faddr;
   logic [31:0] last_addr;
   int          hold;
   logic        live = 1'b0;

   initial begin
      for (int i = 0; i < 4096; i++) kb[i] = 1'b0;
      for (int i = 0; i < 4; i++) iob[i] = 8'h00;
   end

   function automatic logic is_io(input logic [31:0] a);
      return a[31:2] == IO[31:2];
   endfunction

   // A read returns the addressed byte and the bytes above it in the same word.
   function automatic void read_model(input logic [31:0] a, output logic [31:0] v, output logic k);
      int off;
      off = int'(a[1:0]);
      v = '0;
      k = 1'b1;
      if (a < 32'd4096) begin
         for (int j = 0; j < 4 - off; j++) begin
            v[8*j +: 8] = mb[a + 32'(j)];
            k = k & kb[a + 32'(j)];
         end
      end else if (is_io(a)) begin
         for (int j = 0; j < 4 - off; j++) v[8*j +: 8] = iob[off + j];
      end
   endfunction

   always @(posedge clock) begin
      logic [31:0] rv;
      logic        rk;
      logic        unm;
      logic        mis;
      logic        io_w;
      int          nbytes;
      if (reset) begin
         stage_val   = '0;
         stage_known = 1'b1;
         exp_rdata   = '0;
         exp_rknown  = 1'b1;
         exp_strobe  = 1'b0;
         exp_fault   = 1'b0;
         exp_faddr   = '0;
         for (int i = 0; i < 4; i++) iob[i] = 8'h00;
         hold = 0;
         live = 1'b1;
      end else begin
         read_model(mem_addr, rv, rk);
         exp_rdata   = stage_val;
         exp_rknown  = stage_known;
         stage_val   = rv;
         stage_known = rk;
         unm  = !(mem_addr < 32'd4096) && !is_io(mem_addr);
         hold = (hold != 0 && mem_addr == last_addr) ? hold + 1 : 1;
         last_addr = mem_addr;
         mis  = 1'b0;
         io_w = 1'b0;
         if (mem_wenable) begin
            nbytes = (mem_wwidth == write_byte) ? 1 : (mem_wwidth == write_halfword) ? 2 : 4;
            mis = (mem_addr % nbytes) != 0;
            if (!mis && !unm) begin
               for (int j = 0; j < nbytes; j++) begin
                  if (is_io(mem_addr)) iob[(int'(mem_addr[1:0]) + j) % 4] = mem_wdata[8*j +: 8];
                  else begin
                     mb[mem_addr + 32'(j)] = mem_wdata[8*j +: 8];
                     kb[mem_addr + 32'(j)] = 1'b1;
                  end
               end
               io_w = is_io(mem_addr);
            end
         end
         exp_strobe = io_w;
         if ((mem_wenable && (mis || unm)) || (!mem_wenable && unm && hold >= 2)) begin
            if (!exp_fault) exp_faddr = mem_addr;
            exp_fault = 1'b1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerrors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (live) begin
         if (exp_rknown) check("model rdata", mem_rdata, exp_rdata);
         check("model io_out", io_out, {iob[3], iob[2], iob[1], iob[0]});
         check("model io_strobe", {31'b0, io_strobe}, {31'b0, exp_strobe});
         check("model access_fault", {31'b0, access_fault}, {31'b0, exp_fault});
         check("model fault_addr", fault_addr, exp_faddr);
      end
   end

   task automatic tick(input logic [31:0] a, input logic we, input write_width_t w, input logic [31:0] d);
      mem_addr    = a;
      mem_wenable = we;
      mem_wwidth  = w;
      mem_wdata   = d;
      @(posedge clock);
      #1;
   endtask

   task automatic rd(input logic [31:0] a);
      tick(a, 1'b0, write_word, 32'h0);
   endtask

   logic [31:0] ra;
   logic [31:0] prev_ra;
   logic        rwe;
   int          pick;

   initial begin
      reset = 1'b1;
      mem_addr = '0; mem_wenable = 1'b0; mem_wwidth = write_word; mem_wdata = '0;
      repeat (3) rd(32'h0);
      check("reset rdata", mem_rdata, 32'h0);
      check("reset io_out", io_out, 32'h0);
      check("reset strobe", {31'b0, io_strobe}, 32'h0);
      check("reset fault", {31'b0, access_fault}, 32'h0);
      check("reset fault_addr", fault_addr, 32'h0);
      reset = 1'b0;

      // RAM survives reset; read latency after reset release is two edges.
      tick(32'h0, 1'b1, write_word, 32'h00c0_0113);
      reset = 1'b1; rd(32'h0); reset = 1'b0;
      rd(32'h0); check("word0 after 1 edge", mem_rdata, 32'h0);
      rd(32'h0); check("word0 after 2 edges", mem_rdata, 32'h00c0_0113);

      tick(32'h100, 1'b1, write_word, 32'hDEAD_BEEF);
      tick(32'h101, 1'b1, write_byte, 32'h0000_0055);
      rd(32'h100); rd(32'h100); check("SB merge", mem_rdata, 32'hDEAD_55EF);
      rd(32'h103); rd(32'h103); check("read 0x103", mem_rdata, 32'h0000_00DE);

      tick(32'h200, 1'b1, write_word, 32'hCAFE_F00D);
      tick(32'h202, 1'b1, write_halfword, 32'h0000_1234);
      rd(32'h200); rd(32'h200); check("SH upper", mem_rdata, 32'h1234_F00D);
      check("no fault yet", {31'b0, access_fault}, 32'h0);
      tick(32'h203, 1'b1, write_halfword, 32'h0000_ABCD);
      check("misaligned SH fault", {31'b0, access_fault}, 32'h1);
      check("misaligned SH addr", fault_addr, 32'h203);
      rd(32'h200); rd(32'h200); check("misaligned SH no write", mem_rdata, 32'h1234_F00D);
      tick(32'hFFFF_0000, 1'b1, write_word, 32'h1);
      check("first fault wins", fault_addr, 32'h203);

      tick(32'h4, 1'b1, write_word, 32'h1111_1111);
      tick(32'h8, 1'b1, write_word, 32'h2222_2222);
      rd(32'h0);
      rd(32'h4); check("pipe word0", mem_rdata, 32'h00c0_0113);
      rd(32'h8); check("pipe word1", mem_rdata, 32'h1111_1111);
      rd(32'h8); check("pipe word2", mem_rdata, 32'h2222_2222);

      tick(IO, 1'b1, write_word, 32'h0000_00AA);
      check("io_out", io_out, 32'h0000_00AA);
      check("io_strobe pulse", {31'b0, io_strobe}, 32'h1);
      rd(IO); check("io_strobe drop", {31'b0, io_strobe}, 32'h0);
      rd(IO); check("io readback", mem_rdata, 32'h0000_00AA);

      rd(32'h100);
      reset = 1'b1; rd(32'h100); reset = 1'b0;
      check("reset flush", mem_rdata, 32'h0);
      rd(32'h100); rd(32'h100); check("RAM kept", mem_rdata, 32'hDEAD_55EF);
      check("io cleared", io_out, 32'h0);
      check("fault cleared", {31'b0, access_fault}, 32'h0);

      rd(32'hFFFF_0000); check("unmapped read 1 edge", {31'b0, access_fault}, 32'h0);
      rd(32'hFFFF_0000); check("unmapped read held", {31'b0, access_fault}, 32'h1);
      check("unmapped read addr", fault_addr, 32'hFFFF_0000);
      reset = 1'b1; rd(32'h0); reset = 1'b0;

      for (int i = 0; i < 256; i++) tick(32'(i * 4), 1'b1, write_word, $urandom);
      tick(32'hFFC, 1'b1, write_word, $urandom);

      prev_ra = 32'h0;
      for (int i = 0; i < 3000; i++) begin
         pick = $urandom_range(0, 99);
         if (pick < 20)      ra = prev_ra;
         else if (pick < 75) ra = 32'($urandom_range(0, 1023));
         else if (pick < 80) ra = 32'hFFC + 32'($urandom_range(0, 3));
         else if (pick < 90) ra = IO + 32'($urandom_range(0, 3));
         else begin
            case ($urandom_range(0, 3))
               0:       ra = 32'hFFFF_0000;
               1:       ra = IO + 32'h4;
               2:       ra = 32'h1000 + 32'($urandom_range(0, 3));
               default: ra = IO - 32'h4;
            endcase
         end
         reset = ($urandom_range(0, 99) == 0);
         rwe   = !reset && ($urandom_range(0, 2) == 0);
         tick(ra, rwe, write_width_t'($urandom_range(0, 2)), $urandom);
         prev_ra = ra;
      end
      reset = 1'b0;
      rd(32'h0); rd(32'h0);

      $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
      $finish;
   end

endmodule
